brick_map_manager: RTL

- Owns the playfield brick occupancy matrix used by the collision logic and the brick renderer.
- Sequences level loading from a row-organised level ROM.
- Arbitrates brick-destroy requests from two missile collision sources and keeps a count of remaining bricks.
- Sits between the level ROM, the collision controller (which produces hit row/column indices) and the brick drawing logic.

---
 rtl/brick_map_manager.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/brick_map_manager.sv
// Brick occupancy matrix owner: loads levels row by row from the level ROM,
// arbitrates destroy requests from two missiles and counts remaining bricks.
// Latency: hit ack 1 cycle after an eligible request; full load 3*ROWS cycles.
// Backpressure: requests are held by the requester until acked; none are
// served while loading, so they simply wait until the load completes.
// Ports: clk/resetN; levelLoad starts a load; romAddr/romData ROM row access;
// hitReq/hitX*/hitY* destroy requests, hitAck/hitDestroyed responses;
// brickMatrix, bricksLeft, busy, allCleared status.
module brick_map_manager #(
  parameter int ROWS  = 14,
  parameter int COLS  = 17,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         levelLoad,
  output logic [3:0]                   romAddr,
  input  logic [COLS-1:0]              romData,
  input  logic [1:0]                   hitReq,
  input  logic [4:0]                   hitX0,
  input  logic [3:0]                   hitY0,
  input  logic [4:0]                   hitX1,
  input  logic [3:0]                   hitY1,
  output logic [1:0]                   hitAck,
  output logic [1:0]                   hitDestroyed,
  output logic [0:ROWS-1][0:COLS-1]    brickMatrix,
  output logic [CNT_W-1:0]             bricksLeft,
  output logic                         busy,
  output logic                         allCleared
);

  typedef enum logic [1:0] {IDLE, LD_ADDR, LD_WAIT, LD_WR} state_t;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [4:0] COLS_L   = 5'(COLS);
  localparam logic [3:0] ROWS_L   = 4'(ROWS);

  state_t                      state_q, state_d;
  logic [3:0]                  rowCnt_q, rowCnt_d;
  logic [3:0]                  romAddr_q, romAddr_d;
  logic [0:ROWS-1][0:COLS-1]   brickMatrix_q, brickMatrix_d;
  logic [CNT_W-1:0]            bricksLeft_q, bricksLeft_d;
  logic [1:0]                  hitAck_q, hitAck_d;
  logic [1:0]                  hitDestroyed_q, hitDestroyed_d;
  logic                        busy_q, busy_d;
  logic                        rrPtr_q, rrPtr_d;
  logic                        loaded_q, loaded_d;
  logic                        allCleared_q, allCleared_d;

  logic [1:0] elig;
  logic       grant_sel;
  logic [4:0] sel_x;
  logic [3:0] sel_y;

  function automatic logic [CNT_W-1:0] popcount(input logic [COLS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int c = 0; c < COLS; c++) n = n + {{(CNT_W-1){1'b0}}, v[c]};
    return n;
  endfunction

  // A requester whose ack is showing this cycle is finishing its handshake,
  // so it must not be granted again on the same edge.
  assign elig = hitReq & ~hitAck_q;

  always_comb begin
    state_d        = state_q;
    rowCnt_d       = rowCnt_q;
    romAddr_d      = romAddr_q;
    brickMatrix_d  = brickMatrix_q;
    bricksLeft_d   = bricksLeft_q;
    hitAck_d       = '0;
    hitDestroyed_d = '0;
    busy_d         = busy_q;
    rrPtr_d        = rrPtr_q;
    loaded_d       = loaded_q;
    allCleared_d   = (bricksLeft_q == '0) && !busy_q && loaded_q;
    grant_sel      = 1'b0;
    sel_x          = hitX0;
    sel_y          = hitY0;

    case (state_q)
      IDLE: begin
        if (levelLoad) begin
          // Load takes priority; any pending hit stays held until after it.
          state_d      = LD_ADDR;
          rowCnt_d     = '0;
          romAddr_d    = '0;
          bricksLeft_d = '0;
          busy_d       = 1'b1;
          loaded_d     = 1'b0;
        end else if (|elig) begin
          // Both eligible: rrPtr wins. One eligible: it wins. Either way the
          // pointer then favours the requester that was not granted.
          grant_sel = (&elig) ? rrPtr_q : elig[1];
          rrPtr_d   = ~grant_sel;
          sel_x     = grant_sel ? hitX1 : hitX0;
          sel_y     = grant_sel ? hitY1 : hitY0;
          hitAck_d[grant_sel] = 1'b1;
          if ((sel_x < COLS_L) && (sel_y < ROWS_L)) begin
            if (brickMatrix_q[sel_y][sel_x] && (bricksLeft_q != '0)) begin
              brickMatrix_d[sel_y][sel_x] = 1'b0;
              bricksLeft_d                = bricksLeft_q - 1'b1;
              hitDestroyed_d[grant_sel]   = 1'b1;
            end
          end
        end
      end
      LD_ADDR: begin
        romAddr_d = rowCnt_q;
        state_d   = LD_WAIT;
      end
      LD_WAIT: state_d = LD_WR;
      LD_WR: begin
        for (int c = 0; c < COLS; c++) brickMatrix_d[rowCnt_q][c] = romData[c];
        bricksLeft_d = bricksLeft_q + popcount(romData);
        if (rowCnt_q == LAST_ROW) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          loaded_d = 1'b1;
        end else begin
          rowCnt_d = rowCnt_q + 1'b1;
          state_d  = LD_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      rowCnt_q       <= '0;
      romAddr_q      <= '0;
      brickMatrix_q  <= '0;
      bricksLeft_q   <= '0;
      hitAck_q       <= '0;
      hitDestroyed_q <= '0;
      busy_q         <= 1'b0;
      rrPtr_q        <= 1'b0;
      loaded_q       <= 1'b0;
      allCleared_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rowCnt_q       <= rowCnt_d;
      romAddr_q      <= romAddr_d;
      brickMatrix_q  <= brickMatrix_d;
      bricksLeft_q   <= bricksLeft_d;
      hitAck_q       <= hitAck_d;
      hitDestroyed_q <= hitDestroyed_d;
      busy_q         <= busy_d;
      rrPtr_q        <= rrPtr_d;
      loaded_q       <= loaded_d;
      allCleared_q   <= allCleared_d;
    end
  end

  assign romAddr      = romAddr_q;
  assign brickMatrix  = brickMatrix_q;
  assign bricksLeft   = bricksLeft_q;
  assign hitAck       = hitAck_q;
  assign hitDestroyed = hitDestroyed_q;
  assign busy         = busy_q;
  assign allCleared   = allCleared_q;

endmodule
